bcd2bin_seq: RTL and testbench
==============================

// Module: bcd2bin_seq
// PURPOSE
// - Sequential BCD-to-binary converter; the inverse of the binary-to-BCD display path.
// - Takes NDIG packed BCD digits (e.g. decimal entry on SW) and returns the binary value.
// - Uses reverse double-dabble: shift right one bit per clock, then apply a -3 correction per digit.
// - Feeds decimal operator entry into the binary adder/counter datapath; Start comes from a debounced KEY pulse.
// PARAMETERS
// - NDIG  4   number of BCD digits on Bcd.
// - BW    14  output width; must satisfy 2^BW > 10^NDIG-1 and BW <= 4*NDIG.
// PORTS
// - Clk    in   1        clock, rising edge.
// - Clrn   in   1        reset, asynchronous, active-low.
// - Start  in   1        conversion request; sampled only in IDLE.
// - Bcd    in   4*NDIG   packed BCD input, digit 0 in [3:0]; captured on the accepted Start.
// - Bin    out  BW       binary result; holds the last valid result.
// - Busy   out  1        high while a conversion is in progress.
// - Done   out  1        one-cycle pulse when a conversion ends, valid or errored.
// - Err    out  1        set with Done when a captured digit is >9; held until the next accepted Start.
// BEHAVIOUR
// - Reset (Clrn=0, asynchronous): state=IDLE, Bin=0, Busy=0, Done=0, Err=0, shift count=0.
// - Internal registers: digit register D[4*NDIG-1:0], result shift register R[4*NDIG-1:0], counter cnt.
// - IDLE:
//   - Start=1 with all digits <=9: D<=Bcd, R<=0, cnt<=0, Err<=0; go to SHIFT.
//   - Start=1 with any digit >9: Err<=1; go to DONE; Bin unchanged.
// - SHIFT (one iteration per clock):
//   - {D,R} <= {D,R}>>1, with 0 shifted into the MSB.
//   - Every 4-bit digit of the shifted D that is >=8 has 3 subtracted, in the same cycle.
//   - cnt increments each cycle; after 4*NDIG iterations go to DONE.
// - DONE (one cycle): Done=1. If Err=0, Bin<=R[BW-1:0] on entry to DONE. Then return to IDLE.
// - Busy=1 in SHIFT and DONE; Busy=0 in IDLE.
// - Latency, valid input: Start accepted at edge 0; Bin valid and Done=1 in cycle 4*NDIG+1 (17 for NDIG=4).
// - Latency, invalid input: Done=1 in the cycle after Start is accepted.
// - A new Start is accepted no earlier than the cycle after Done.
// - Start while Busy=1 is ignored. It is not queued, and Bcd changes are ignored.
// - Start held high continuously causes back-to-back conversions, one per 4*NDIG+2 cycles.
// - Arithmetic:
//   - Every digit correction is unsigned 4-bit. A digit >=8 can only arise from a valid digit, so no underflow.
//   - R upper bits above BW are always 0 for valid input; they are discarded.
// - Clrn asserted mid-conversion: immediate abort to the reset values; no Done pulse.
// - States are IDLE=2'd0, SHIFT=2'd1, DONE=2'd2. Encoding 2'd3 is unreachable and recovers to IDLE.
// STRUCTURE
// - Shared include: the state encodings, the NDIG/BW defaults, and the BCD digit max (4'd9). These are also used by the display path.
// - Sub-module bcd_digit_adj: 4-bit combinational block, out = (in>=8) ? in-3 : in.
//   - Instantiated NDIG times in a generate loop on the shifted D.
// - Top level: the FSM, cnt (width $clog2(4*NDIG+1)), the D/R registers, and the digit-validity check (NDIG comparators on Bcd).
// TESTING
// - Bcd=16'h0000, Start pulse -> Done in cycle 17, Bin=14'd0, Err=0.
// - Bcd=16'h9999 -> Bin=14'h270F (9999) at Done, Busy high for 17 cycles.
// - Bcd=16'h1234 -> Bin=14'h04D2. Then Bcd=16'h0010 -> Bin=14'h000A. Done is exactly one cycle each time.
// - Bcd=16'h12A4 -> Err=1 with Done one cycle after Start; Bin keeps the prior 14'h000A. Next valid Start clears Err.
// - Start again in cycle 5 of a conversion, with Bcd changed -> ignored; result matches the originally captured Bcd.
// - Clrn low during cycle 8 of a conversion -> all outputs 0 immediately, no Done pulse. A fresh Start after release converts normally.

Source files
------------

// File: rtl/bcd2bin_seq_pkg.sv
// Shared definitions for the BCD conversion paths: state encodings, default sizes, digit limit.
package bcd2bin_seq_pkg;

  localparam int unsigned NdigDefault = 4;
  localparam int unsigned BwDefault   = 14;
  localparam logic [3:0]  BcdDigitMax = 4'd9;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  function automatic logic digit_valid(input logic [3:0] digit);
    return digit <= BcdDigitMax;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: subtract 3 from any digit that reached 8 or more.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd8) begin
      dout = din - 4'd3;
    end
  end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one shift per clock.
module bcd2bin_seq
  import bcd2bin_seq_pkg::*;
#(
  parameter int unsigned NDIG = NdigDefault,
  parameter int unsigned BW   = BwDefault
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic              Start,
  input  logic [4*NDIG-1:0] Bcd,
  output logic [BW-1:0]     Bin,
  output logic              Busy,
  output logic              Done,
  output logic              Err
);

  localparam int unsigned W    = 4 * NDIG;
  localparam int unsigned CntW = $clog2(W + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    d_q, d_d;
  logic [W-1:0]    r_q, r_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [BW-1:0]   bin_q, bin_d;
  logic            err_q, err_d;

  logic [W-1:0]    d_shift, d_adj, r_shift;
  logic [NDIG-1:0] dig_ok;
  logic            bcd_ok;

  // {D,R} shifted right as one register; D's LSB falls into R's MSB.
  assign d_shift = {1'b0, d_q[W-1:1]};
  assign r_shift = {d_q[0], r_q[W-1:1]};

  for (genvar g = 0; g < NDIG; g++) begin : gen_digit
    bcd_digit_adj u_adj (
      .din  (d_shift[4*g +: 4]),
      .dout (d_adj[4*g +: 4])
    );
    assign dig_ok[g] = digit_valid(Bcd[4*g +: 4]);
  end

  assign bcd_ok = &dig_ok;

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (Start) begin
          if (bcd_ok) begin
            d_d     = Bcd;
            r_d     = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = StShift;
          end else begin
            err_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StShift: begin
        d_d   = d_adj;
        r_d   = r_shift;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StDone;
          bin_d   = r_shift[BW-1:0];
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q <= StIdle;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign Bin  = bin_q;
  assign Busy = (state_q == StShift) || (state_q == StDone);
  assign Done = (state_q == StDone);
  assign Err  = err_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed self-checking bench for bcd2bin_seq (NDIG=4, BW=14).
module tb_bcd2bin_seq;

  logic        Clk;
  logic        Clrn;
  logic        Start;
  logic [15:0] Bcd;
  logic [13:0] Bin;
  logic        Busy;
  logic        Done;
  logic        Err;

  int pass_cnt  = 0;
  int check_cnt = 0;

  // Results of the last run_conv call.
  int          done_cyc;
  int          done_width;
  int          busy_cyc;
  logic [13:0] bin_at_done;
  logic        err_at_done;

  bcd2bin_seq #(.NDIG(4), .BW(14)) dut (
    .Clk   (Clk),
    .Clrn  (Clrn),
    .Start (Start),
    .Bcd   (Bcd),
    .Bin   (Bin),
    .Busy  (Busy),
    .Done  (Done),
    .Err   (Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Pulse Start for one edge, then observe 20 cycles. Cycle 1 follows the accepting edge.
  // A non-zero restart_cyc raises Start with new_bcd during that cycle (must be ignored).
  task automatic run_conv(input logic [15:0] bcd, input int restart_cyc,
                          input logic [15:0] new_bcd);
    done_cyc    = -1;
    done_width  = 0;
    busy_cyc    = 0;
    bin_at_done = 'x;
    err_at_done = 1'bx;
    @(negedge Clk);
    Start = 1'b1;
    Bcd   = bcd;
    @(negedge Clk);
    Start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge Clk);
      Start = (c == restart_cyc);
      if (c == restart_cyc) Bcd = new_bcd;
      if (Busy) busy_cyc++;
      if (Done) begin
        done_width++;
        if (done_cyc < 0) begin
          done_cyc    = c;
          bin_at_done = Bin;
          err_at_done = Err;
        end
      end
    end
    Start = 1'b0;
  endtask

  task automatic test_reset();
    Clrn  = 1'b0;
    Start = 1'b0;
    Bcd   = '0;
    #12;
    check_cnt++; if (Bin !== 14'd0) $display("FAIL reset_bin got %h want 0", Bin); else pass_cnt++;
    check_cnt++; if (Busy !== 1'b0) $display("FAIL reset_busy got %b want 0", Busy); else pass_cnt++;
    check_cnt++; if (Done !== 1'b0) $display("FAIL reset_done got %b want 0", Done); else pass_cnt++;
    check_cnt++; if (Err !== 1'b0) $display("FAIL reset_err got %b want 0", Err); else pass_cnt++;
    @(negedge Clk);
    Clrn = 1'b1;
  endtask

  task automatic test_zero();
    run_conv(16'h0000, 0, 16'h0);
    check_cnt++; if (done_cyc !== 17) $display("FAIL zero_latency got %0d want 17", done_cyc); else pass_cnt++;
    check_cnt++; if (bin_at_done !== 14'd0) $display("FAIL zero_bin got %h want 0", bin_at_done); else pass_cnt++;
    check_cnt++; if (err_at_done !== 1'b0) $display("FAIL zero_err got %b want 0", err_at_done); else pass_cnt++;
    check_cnt++; if (done_width !== 1) $display("FAIL zero_done_width got %0d want 1", done_width); else pass_cnt++;
  endtask

  task automatic test_max();
    run_conv(16'h9999, 0, 16'h0);
    check_cnt++; if (bin_at_done !== 14'h270F) $display("FAIL max_bin got %h want 270f", bin_at_done); else pass_cnt++;
    check_cnt++; if (busy_cyc !== 17) $display("FAIL max_busy got %0d want 17", busy_cyc); else pass_cnt++;
    check_cnt++; if (done_cyc !== 17) $display("FAIL max_latency got %0d want 17", done_cyc); else pass_cnt++;
  endtask

  task automatic test_sequence();
    run_conv(16'h1234, 0, 16'h0);
    check_cnt++; if (bin_at_done !== 14'h04D2) $display("FAIL seq1234_bin got %h want 04d2", bin_at_done); else pass_cnt++;
    check_cnt++; if (done_width !== 1) $display("FAIL seq1234_width got %0d want 1", done_width); else pass_cnt++;
    run_conv(16'h0010, 0, 16'h0);
    check_cnt++; if (bin_at_done !== 14'h000A) $display("FAIL seq0010_bin got %h want 000a", bin_at_done); else pass_cnt++;
    check_cnt++; if (done_width !== 1) $display("FAIL seq0010_width got %0d want 1", done_width); else pass_cnt++;
  endtask

  task automatic test_invalid();
    run_conv(16'h12A4, 0, 16'h0);
    check_cnt++; if (done_cyc !== 1) $display("FAIL inv_latency got %0d want 1", done_cyc); else pass_cnt++;
    check_cnt++; if (err_at_done !== 1'b1) $display("FAIL inv_err got %b want 1", err_at_done); else pass_cnt++;
    check_cnt++; if (bin_at_done !== 14'h000A) $display("FAIL inv_bin_kept got %h want 000a", bin_at_done); else pass_cnt++;
    check_cnt++; if (busy_cyc !== 1) $display("FAIL inv_busy got %0d want 1", busy_cyc); else pass_cnt++;
    check_cnt++; if (Err !== 1'b1) $display("FAIL inv_err_held got %b want 1", Err); else pass_cnt++;
    run_conv(16'h0007, 0, 16'h0);
    check_cnt++; if (err_at_done !== 1'b0) $display("FAIL inv_err_cleared got %b want 0", err_at_done); else pass_cnt++;
    check_cnt++; if (bin_at_done !== 14'd7) $display("FAIL inv_next_bin got %h want 0007", bin_at_done); else pass_cnt++;
  endtask

  task automatic test_ignore_start();
    run_conv(16'h0456, 5, 16'h0999);
    check_cnt++; if (bin_at_done !== 14'd456) $display("FAIL ign_bin got %0d want 456", bin_at_done); else pass_cnt++;
    check_cnt++; if (done_cyc !== 17) $display("FAIL ign_latency got %0d want 17", done_cyc); else pass_cnt++;
    check_cnt++; if (busy_cyc !== 17) $display("FAIL ign_no_requeue got %0d busy cycles want 17", busy_cyc); else pass_cnt++;
  endtask

  task automatic test_abort();
    int dones;
    @(negedge Clk);
    Start = 1'b1;
    Bcd   = 16'h0321;
    @(negedge Clk);
    Start = 1'b0;
    for (int c = 2; c <= 8; c++) @(negedge Clk);
    Clrn = 1'b0;
    #1;
    check_cnt++; if ({Bin, Busy, Done, Err} !== 17'd0)
      $display("FAIL abort_outputs got bin=%h busy=%b done=%b err=%b want all 0", Bin, Busy, Done, Err);
    else pass_cnt++;
    @(negedge Clk);
    Clrn  = 1'b1;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      if (Done) dones++;
    end
    check_cnt++; if (dones !== 0) $display("FAIL abort_no_done got %0d pulses want 0", dones); else pass_cnt++;
    run_conv(16'h0321, 0, 16'h0);
    check_cnt++; if (bin_at_done !== 14'd321) $display("FAIL abort_restart_bin got %0d want 321", bin_at_done); else pass_cnt++;
    check_cnt++; if (done_cyc !== 17) $display("FAIL abort_restart_latency got %0d want 17", done_cyc); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int first_done;
    int second_done;
    first_done  = -1;
    second_done = -1;
    @(negedge Clk);
    Start = 1'b1;
    Bcd   = 16'h0050;
    @(negedge Clk);
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge Clk);
      if (Done) begin
        if (first_done < 0) first_done = c;
        else if (second_done < 0) second_done = c;
      end
    end
    Start = 1'b0;
    check_cnt++; if (first_done !== 17) $display("FAIL b2b_first got %0d want 17", first_done); else pass_cnt++;
    check_cnt++; if (second_done !== 35) $display("FAIL b2b_second got %0d want 35", second_done); else pass_cnt++;
    check_cnt++; if (Bin !== 14'd50) $display("FAIL b2b_bin got %0d want 50", Bin); else pass_cnt++;
    for (int c = 0; c < 20; c++) @(negedge Clk);
  endtask

  initial begin
    test_reset();
    test_zero();
    test_max();
    test_sequence();
    test_invalid();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
